// File: rtl/uart_pkg.sv
// Shared definitions for the UART 16550 FIFO data paths: default geometry,
// FCR[7:6] trigger-level encodings and the trigger-level lookup.
package uart_pkg;

    localparam int DEF_DEPTH = 16;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_ERRW  = 3;

    // FCR[7:6] trigger select: one entry, quarter, half, nearly full
    typedef enum logic [1:0] {
        TRIG_1  = 2'b00,
        TRIG_Q  = 2'b01,
        TRIG_H  = 2'b10,
        TRIG_NF = 2'b11
    } trig_sel_e;

    // Entry count at which the trigger output asserts for a given selection
    function automatic int unsigned trig_level(input logic [1:0] sel, input int unsigned depth);
        int unsigned lvl;
        case (trig_sel_e'(sel))
            TRIG_1:  lvl = 32'd1;
            TRIG_Q:  lvl = depth / 32'd4;
            TRIG_H:  lvl = depth / 32'd2;
            TRIG_NF: lvl = depth - 32'd2;
            default: lvl = 32'd1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Storage array for uart_fifo_trig: DEPTH words of MW bits, one synchronous
// write port and one asynchronous (combinational) read port. Contents are not
// reset; the surrounding pointer logic decides which words are valid.
module uart_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int MW    = 11
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [MW-1:0]            i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [MW-1:0]            o_rdata
);

    logic [MW-1:0] r_mem [DEPTH];

    // Write port: store the incoming word at the write address
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_fifo_trig.sv
// UART 16550 TX/RX FIFO with per-entry error tag, programmable trigger level,
// sticky overrun and error-in-FIFO flag.
// Build option: UART_FIFO_FWFT_EN selects first-word-fall-through outputs;
// without it data_o/err_o are registered with one cycle of read latency.
module uart_fifo_trig
    import uart_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int ERRW  = DEF_ERRW
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          fifo_rst,
    input  logic                          write,
    input  logic [WIDTH-1:0]              data_i,
    input  logic [((ERRW>0)?ERRW:1)-1:0]  err_i,
    input  logic                          read,
    input  logic [1:0]                    trig_sel,
    input  logic                          ovr_clr,
    output logic [WIDTH-1:0]              data_o,
    output logic [((ERRW>0)?ERRW:1)-1:0]  err_o,
    output logic                          wfull,
    output logic                          rempty,
    output logic [$clog2(DEPTH):0]        fifo_cnt,
    output logic                          trig,
    output logic                          err_in_fifo,
    output logic                          overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = (ERRW > 0) ? ERRW : 1;
    localparam int MW = WIDTH + EW;

    localparam logic [CW-1:0] C_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};

    // pointers carry a wrap bit above the address bits
    logic [CW-1:0]    r_wptr;
    logic [CW-1:0]    r_rptr;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    r_err_cnt;
    logic             r_overrun;
    logic [WIDTH-1:0] r_data;
    logic [EW-1:0]    r_err;

    logic             w_empty;
    logic             w_full;
    logic             w_rd_ok;
    logic             w_wr_ok;
    logic [EW-1:0]    w_err_in;
    logic             w_err_wr;
    logic             w_err_rd;
    logic [MW-1:0]    w_head;
    logic [WIDTH-1:0] w_head_data;
    logic [EW-1:0]    w_head_err;
    logic [CW-1:0]    w_cnt_nxt;
    logic [CW-1:0]    w_err_cnt_nxt;
    logic [CW-1:0]    w_level;

    uart_fifo_ram #(
        .DEPTH (DEPTH),
        .MW    (MW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata ({w_err_in, data_i}),
        .i_raddr (r_rptr[AW-1:0]),
        .o_rdata (w_head)
    );

    assign w_head_data = w_head[WIDTH-1:0];
    assign w_head_err  = w_head[MW-1:WIDTH];

    // Status decode and acceptance of this cycle's read/write requests
    always_comb begin
        w_empty  = (r_wptr == r_rptr);
        w_full   = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
        // a read on an empty FIFO is ignored; a write into a full FIFO only
        // succeeds when an accepted read frees the head slot on the same edge
        w_rd_ok  = read && !w_empty;
        w_wr_ok  = write && (!w_full || w_rd_ok);
        // without error-tag storage the tag is forced to zero
        if (ERRW > 0) begin
            w_err_in = err_i;
        end else begin
            w_err_in = {EW{1'b0}};
        end
        w_err_wr = w_wr_ok && (w_err_in != {EW{1'b0}});
        w_err_rd = w_rd_ok && (w_head_err != {EW{1'b0}});
    end

    // Next stored-entry count and next errored-entry count
    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_cnt_nxt = r_cnt + C_ONE;
            2'b01:   w_cnt_nxt = r_cnt - C_ONE;
            default: w_cnt_nxt = r_cnt;
        endcase
        w_err_cnt_nxt = r_err_cnt;
        case ({w_err_wr, w_err_rd})
            2'b10:   w_err_cnt_nxt = r_err_cnt + C_ONE;
            2'b01:   w_err_cnt_nxt = r_err_cnt - C_ONE;
            default: w_err_cnt_nxt = r_err_cnt;
        endcase
    end

    // Pointer, counter and overrun state with async reset and FCR clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr    <= C_ZERO;
            r_rptr    <= C_ZERO;
            r_cnt     <= C_ZERO;
            r_err_cnt <= C_ZERO;
            r_overrun <= 1'b0;
        end else if (!fifo_rst) begin
            r_wptr    <= C_ZERO;
            r_rptr    <= C_ZERO;
            r_cnt     <= C_ZERO;
            r_err_cnt <= C_ZERO;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + C_ONE;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + C_ONE;
            end
            r_cnt     <= w_cnt_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            // a dropped write takes priority over the LSR-read clear
            if (write && !w_wr_ok) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Output register: captures the popped entry on each accepted read
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data <= {WIDTH{1'b0}};
            r_err  <= {EW{1'b0}};
        end else if (!fifo_rst) begin
            r_data <= {WIDTH{1'b0}};
            r_err  <= {EW{1'b0}};
        end else if (w_rd_ok) begin
            r_data <= w_head_data;
            r_err  <= w_head_err;
        end
    end

    // Trigger threshold for the selected level
    always_comb begin
        w_level = CW'(trig_level(trig_sel, DEPTH));
    end

    assign wfull       = w_full;
    assign rempty      = w_empty;
    assign fifo_cnt    = r_cnt;
    assign trig        = (r_cnt >= w_level);
    assign err_in_fifo = (r_err_cnt != C_ZERO);
    assign overrun     = r_overrun;

`ifdef UART_FIFO_FWFT_EN
    // head entry is visible immediately; the register keeps the last popped
    // entry so the outputs hold while the FIFO is empty
    assign data_o = w_empty ? r_data : w_head_data;
    assign err_o  = w_empty ? r_err  : w_head_err;
`else
    assign data_o = r_data;
    assign err_o  = r_err;
`endif

endmodule
